// File: rtl/invert_d.sv
// invert_d: registered, maskable bitwise inverter for byte-wide data paths.
// Each accepted word is XORed with a per-bit invert mask and registered.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   a          data word to invert
//   in_valid   a and mask are sampled on a rising clk edge when high
//   mask       per-bit invert enable (1 = invert, 0 = pass through)
//   y          registered result, a ^ mask
//   out_valid  high for one cycle after each accepted word
//   changed    high with out_valid when the new y differs from the previous y
//   parity     XOR-reduction of the current y (from the register only)
module invert_d #(
  parameter int unsigned           WIDTH   = 8,
  parameter logic [WIDTH-1:0]      RESET_Y = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             changed,
  output logic             parity
);

  logic [WIDTH-1:0] y_next;

  always_comb begin
    y_next = a ^ mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y         <= RESET_Y;
      out_valid <= 1'b0;
      changed   <= 1'b0;
    end else if (in_valid) begin
      y         <= y_next;
      out_valid <= 1'b1;
      // Compared against the value being replaced, so the first word after
      // reset is measured against RESET_Y.
      changed   <= (y_next != y);
    end else begin
      out_valid <= 1'b0;
      changed   <= 1'b0;
    end
  end

  assign parity = ^y;

endmodule

// File: tb/tb_invert_d.sv
module tb_invert_d;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic       in_valid;
  logic [7:0] mask;
  logic [7:0] y;
  logic       out_valid;
  logic       changed;
  logic       parity;

  int unsigned total;
  int unsigned bad;

  invert_d #(.WIDTH(8), .RESET_Y(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .in_valid  (in_valid),
    .mask      (mask),
    .y         (y),
    .out_valid (out_valid),
    .changed   (changed),
    .parity    (parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check all four outputs in one go.
  task automatic chk_all(input string tag, input logic [7:0] ey, input logic eov,
                         input logic ech, input logic epar);
    chk({tag, ".y"},         {24'h0, y},         {24'h0, ey});
    chk({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, eov});
    chk({tag, ".changed"},   {31'h0, changed},   {31'h0, ech});
    chk({tag, ".parity"},    {31'h0, parity},    {31'h0, epar});
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic v, input logic [7:0] av, input logic [7:0] mv);
    in_valid = v;
    a        = av;
    mask     = mv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 8'h00;
    mask     = 8'hFF;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // First word, full inversion
    step(1'b1, 8'h88, 8'hFF);
    chk_all("first_88", 8'h77, 1'b1, 1'b1, 1'b0);

    // Back-to-back
    step(1'b1, 8'h99, 8'hFF);
    chk_all("b2b_99", 8'h66, 1'b1, 1'b1, 1'b0);
    step(1'b1, 8'h99, 8'hFF);
    chk_all("b2b_99_same", 8'h66, 1'b1, 1'b0, 1'b0);

    // Idle hold, a changes but is not sampled
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 8'hFF);
      chk_all("idle", 8'h66, 1'b0, 1'b0, 1'b0);
    end

    // Mask variants with a = A5
    step(1'b1, 8'hA5, 8'h00);
    chk_all("mask_00", 8'hA5, 1'b1, 1'b1, 1'b0);
    step(1'b1, 8'hA5, 8'h0F);
    chk_all("mask_0F", 8'hAA, 1'b1, 1'b1, 1'b0);
    step(1'b1, 8'hA5, 8'hFF);
    chk_all("mask_FF", 8'h5A, 1'b1, 1'b1, 1'b0);

    // Async reset mid-stream
    step(1'b1, 8'h33, 8'hFF);
    chk_all("pre_rst", 8'hCC, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("rst_held", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // First word after reset compares against RESET_Y
    step(1'b1, 8'hFF, 8'hFF);
    chk_all("post_rst_FF", 8'h00, 1'b1, 1'b0, 1'b0);

    // Boundary values
    step(1'b1, 8'h00, 8'hFF);
    chk_all("bound_00", 8'hFF, 1'b1, 1'b1, 1'b0);
    step(1'b1, 8'h01, 8'hFF);
    chk_all("bound_01", 8'hFE, 1'b1, 1'b1, 1'b1);

    // out_valid drops after the stream ends
    step(1'b0, 8'h5A, 8'h00);
    chk_all("end_idle", 8'hFE, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
